// File: rtl/me_search_ctrl_pkg.sv
// Shared types and derived-width helpers for the motion-estimation search controller.
package me_search_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Width of one lane of the SAD bus: pixel depth plus 2*log2(edge) for the accumulation.
  function automatic int sad_width(input int log_edge_len, input int bit_depth);
    return 2 * log_edge_len + bit_depth;
  endfunction

  function automatic int num_cand(input int search_cols, input int edge_len);
    return search_cols - edge_len + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_W     = sad_width(3, 8);
  localparam int DEF_NCAND = num_cand(32, 8);
  localparam int DEF_YW    = idx_width(16);

endpackage

// File: rtl/me_search_ctrl_sad_min_tree.sv
// Combinational minimum over all SAD lanes; the lowest lane index wins a tie.
module sad_min_tree #(
  parameter int LANES = 16,
  parameter int W     = 14,
  parameter int IW    = 4
) (
  input  logic [LANES*W-1:0] lanes_i,
  output logic [W-1:0]       min_o,
  output logic [IW-1:0]      idx_o
);

  logic [W-1:0]  cur_min;
  logic [IW-1:0] cur_idx;

  always_comb begin
    cur_min = lanes_i[W-1:0];
    cur_idx = '0;
    // Strict less-than keeps the earlier lane on equal values.
    for (int k = 1; k < LANES; k++) begin
      if (lanes_i[k*W +: W] < cur_min) begin
        cur_min = lanes_i[k*W +: W];
        cur_idx = IW'(k);
      end
    end
    min_o = cur_min;
    idx_o = cur_idx;
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Search controller: streams reference columns into the SAD array and tracks the best candidate.
// Handshake: start is a single-cycle request taken only in IDLE; busy covers LOAD..DONE; done pulses once.
module me_search_ctrl
  import me_search_ctrl_pkg::*;
#(
  parameter int EDGE_LEN        = 8,
  parameter int LOG_EDGE_LEN    = 3,
  parameter int BIT_DEPTH       = 8,
  parameter int PIXELS_IN_BATCH = 16,
  parameter int SEARCH_COLS     = 32,
  parameter int LOG_SEARCH_COLS = 5,
  parameter int ARRAY_LATENCY   = 2 * EDGE_LEN,
  localparam int W              = sad_width(LOG_EDGE_LEN, BIT_DEPTH),
  localparam int YW             = idx_width(PIXELS_IN_BATCH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         cur_load,
  output logic                         ref_col_en,
  output logic [LOG_SEARCH_COLS-1:0]   ref_col_addr,
  input  logic [PIXELS_IN_BATCH*W-1:0] sad_in,
  output logic                         done,
  output logic [W-1:0]                 best_sad,
  output logic [LOG_SEARCH_COLS-1:0]   best_x,
  output logic [YW-1:0]                best_y,
  output state_e                       dbg_state
);

  localparam int NCAND = num_cand(SEARCH_COLS, EDGE_LEN);
  localparam logic [LOG_SEARCH_COLS-1:0] LAST_COL   = LOG_SEARCH_COLS'(SEARCH_COLS - 1);
  localparam logic [LOG_SEARCH_COLS-1:0] FIRST_CAND = LOG_SEARCH_COLS'(EDGE_LEN - 1);
  localparam logic [LOG_SEARCH_COLS-1:0] LAST_CAND  = LOG_SEARCH_COLS'(NCAND - 1);

  state_e                       state_q, state_d;
  logic [LOG_SEARCH_COLS-1:0]   col_q, col_d;
  logic [LOG_SEARCH_COLS-1:0]   cand_x_q, cand_x_d;
  logic [ARRAY_LATENCY-1:0]     dly_q, dly_d;
  logic [W-1:0]                 min_q, min_d;
  logic [LOG_SEARCH_COLS-1:0]   min_x_q, min_x_d;
  logic [YW-1:0]                min_y_q, min_y_d;
  logic [W-1:0]                 best_sad_q, best_sad_d;
  logic [LOG_SEARCH_COLS-1:0]   best_x_q, best_x_d;
  logic [YW-1:0]                best_y_q, best_y_d;

  logic [W-1:0]  lane_min;
  logic [YW-1:0] lane_idx;
  logic          sample_v;
  logic          last_sample;
  logic          take;

  sad_min_tree #(
    .LANES (PIXELS_IN_BATCH),
    .W     (W),
    .IW    (YW)
  ) u_min_tree (
    .lanes_i (sad_in),
    .min_o   (lane_min),
    .idx_o   (lane_idx)
  );

  // The delay line carries one flag per candidate-producing issue; its tail marks the sample cycle.
  assign sample_v    = dly_q[ARRAY_LATENCY-1];
  assign last_sample = sample_v && (cand_x_q == LAST_CAND);
  assign take        = sample_v && (lane_min < min_q);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cand_x_d   = cand_x_q;
    dly_d      = dly_q << 1;
    min_d      = min_q;
    min_x_d    = min_x_q;
    min_y_d    = min_y_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    cur_load   = 1'b0;
    ref_col_en = 1'b0;
    done       = 1'b0;

    if (sample_v) begin
      cand_x_d = cand_x_q + 1'b1;
      if (take) begin
        min_d   = lane_min;
        min_x_d = cand_x_q;
        min_y_d = lane_idx;
      end
    end
    // Fold the final sample straight into the result so best_* is already valid during DONE.
    if (last_sample) begin
      best_sad_d = take ? lane_min : min_q;
      best_x_d   = take ? cand_x_q : min_x_q;
      best_y_d   = take ? lane_idx : min_y_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cur_load = 1'b1;
        min_d    = '1;
        min_x_d  = '0;
        min_y_d  = '0;
        cand_x_d = '0;
        col_d    = '0;
        dly_d    = '0;
        state_d  = ST_FEED;
      end
      ST_FEED: begin
        ref_col_en = 1'b1;
        dly_d[0]   = (col_q >= FIRST_CAND);
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (last_sample) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      cand_x_q   <= '0;
      dly_q      <= '0;
      min_q      <= '1;
      min_x_q    <= '0;
      min_y_q    <= '0;
      best_sad_q <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cand_x_q   <= cand_x_d;
      dly_q      <= dly_d;
      min_q      <= min_d;
      min_x_q    <= min_x_d;
      min_y_q    <= min_y_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign ref_col_addr = col_q;
  assign best_sad     = best_sad_q;
  assign best_x       = best_x_q;
  assign best_y       = best_y_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: emulated SAD array, vector table, random searches, reset corner cases.
module tb_me_search_ctrl;
  import me_search_ctrl_pkg::*;

  localparam int EDGE_LEN    = 8;
  localparam int LANES       = 16;
  localparam int SEARCH_COLS = 32;
  localparam int LAT         = 2 * EDGE_LEN;
  localparam int W           = 14;
  localparam int NCAND       = SEARCH_COLS - EDGE_LEN + 1;
  localparam int DONE_OFF    = 2 + SEARCH_COLS - 1 + LAT + 1;
  localparam int SAD_MAX     = (1 << W) - 1;

  logic             clk, rst, start;
  logic             busy, cur_load, ref_col_en, done;
  logic [4:0]       ref_col_addr;
  logic [LANES*W-1:0] sad_in;
  logic [W-1:0]     best_sad;
  logic [4:0]       best_x;
  logic [3:0]       best_y;
  state_e           dbg_state;

  me_search_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .cur_load     (cur_load),
    .ref_col_en   (ref_col_en),
    .ref_col_addr (ref_col_addr),
    .sad_in       (sad_in),
    .done         (done),
    .best_sad     (best_sad),
    .best_x       (best_x),
    .best_y       (best_y),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] cand [NCAND][LANES];
  int           issue_q[$];
  logic [W-1:0] exp_q[$];

  typedef struct {
    int mode;       // 0 spot on background, 1 random small (ties), 2 random full range
    int bg;
    int sx;
    int sy;
    int sv;
    int repulse;    // FEED cycle to re-pulse start, -1 for none
    bit start_in_done;
    bit use_model;
    int exp_sad;
    int exp_x;
    int exp_y;
  } vec_t;

  function automatic vec_t mk(int mode, int bg, int sx, int sy, int sv, int repulse,
                              bit sid, bit use_model, int es, int ex, int ey);
    vec_t v;
    v.mode = mode; v.bg = bg; v.sx = sx; v.sy = sy; v.sv = sv;
    v.repulse = repulse; v.start_in_done = sid; v.use_model = use_model;
    v.exp_sad = es; v.exp_x = ex; v.exp_y = ey;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Array model: whatever column was issued LAT cycles ago appears on sad_in now.
  task automatic tick();
    int c;
    @(posedge clk);
    #1;
    cyc++;
    issue_q.push_back(ref_col_en ? int'(ref_col_addr) : -1);
    c = issue_q.pop_front();
    for (int k = 0; k < LANES; k++) begin
      if (c >= EDGE_LEN - 1 && c < SEARCH_COLS) sad_in[k*W +: W] = cand[c-(EDGE_LEN-1)][k];
      else sad_in[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic fill(input vec_t v);
    for (int x = 0; x < NCAND; x++)
      for (int k = 0; k < LANES; k++)
        case (v.mode)
          0:       cand[x][k] = W'(v.bg);
          1:       cand[x][k] = W'($urandom_range(0, 15));
          default: cand[x][k] = W'($urandom);
        endcase
    if (v.mode == 0) cand[v.sx][v.sy] = W'(v.sv);
  endtask

  // Reference: smallest value overall, then the first (x, then lane) position holding it.
  task automatic model(output int s, output int bx, output int by);
    bit found;
    s = SAD_MAX;
    for (int x = 0; x < NCAND; x++)
      for (int k = 0; k < LANES; k++)
        if (int'(cand[x][k]) < s) s = int'(cand[x][k]);
    found = 0; bx = 0; by = 0;
    for (int x = 0; x < NCAND; x++)
      for (int k = 0; k < LANES; k++)
        if (!found && int'(cand[x][k]) == s) begin
          found = 1; bx = x; by = k;
        end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    int s, es, ex, ey;
    int cl_cnt, cl_cyc, en_cnt, first_en, last_en, addr_err, busy_err, done_cnt, done_cyc;
    logic [W-1:0] got_sad;
    logic [4:0]   got_x;
    logic [3:0]   got_y;
    bit           exp_busy;
    fill(v);
    if (v.use_model) model(es, ex, ey);
    else begin es = v.exp_sad; ex = v.exp_x; ey = v.exp_y; end
    exp_q.push_back(W'(es));
    exp_q.push_back(W'(ex));
    exp_q.push_back(W'(ey));
    cl_cnt = 0; cl_cyc = -1; en_cnt = 0; first_en = -1; last_en = -1;
    addr_err = 0; busy_err = 0; done_cnt = 0; done_cyc = -1;
    got_sad = '0; got_x = '0; got_y = '0;
    s = cyc;
    start = 1'b1;
    for (int i = 0; i < DONE_OFF + 3; i++) begin
      tick();
      start = 1'b0;
      if (cur_load) begin cl_cnt++; cl_cyc = cyc; end
      if (ref_col_en) begin
        if (en_cnt == 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
        if (int'(ref_col_addr) != cyc - (s + 2)) addr_err++;
      end
      exp_busy = (cyc >= s + 1) && (cyc <= s + DONE_OFF);
      if (busy !== exp_busy) busy_err++;
      if (done) begin
        done_cnt++; done_cyc = cyc;
        got_sad = best_sad; got_x = best_x; got_y = best_y;
      end
      if (v.repulse >= 0 && cyc == s + 2 + v.repulse) start = 1'b1;
      if (v.start_in_done && done) start = 1'b1;
    end
    start = 1'b0;
    check({tag, " cur_load_count"}, cl_cnt, 1);
    check({tag, " cur_load_cycle"}, cl_cyc, s + 1);
    check({tag, " col_en_count"}, en_cnt, SEARCH_COLS);
    check({tag, " col_en_span"}, last_en - first_en + 1, SEARCH_COLS);
    check({tag, " col_en_first"}, first_en, s + 2);
    check({tag, " col_addr_errs"}, addr_err, 0);
    check({tag, " busy_errs"}, busy_err, 0);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_cycle"}, done_cyc, s + DONE_OFF);
    check({tag, " best_sad"}, got_sad, exp_q.pop_front());
    check({tag, " best_x"}, got_x, exp_q.pop_front());
    check({tag, " best_y"}, got_y, exp_q.pop_front());
    check({tag, " best_sad_held"}, best_sad, es);
    check({tag, " best_x_held"}, best_x, ex);
    check({tag, " best_y_held"}, best_y, ey);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " cur_load"}, cur_load, 0);
    check({tag, " ref_col_en"}, ref_col_en, 0);
    check({tag, " ref_col_addr"}, ref_col_addr, 0);
    check({tag, " best_sad"}, best_sad, 0);
    check({tag, " best_x"}, best_x, 0);
    check({tag, " best_y"}, best_y, 0);
    check({tag, " state_idle"}, dbg_state == ST_IDLE, 1);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];

  initial begin
    int s, done_cnt;
    vecs[0] = mk(0, 100,  7,  3,  5, -1, 0, 0,  5,  7,  3);
    vecs[1] = mk(0,  42,  0,  0, 42, -1, 0, 0, 42,  0,  0);
    vecs[2] = mk(0,   1, 24, 15,  0, -1, 0, 0,  0, 24, 15);
    vecs[3] = mk(0, 300, 12,  9,  7, 10, 1, 0,  7, 12,  9);
    vecs[4] = mk(0, SAD_MAX, 5, 5, SAD_MAX, -1, 0, 0, SAD_MAX, 0, 0);
    vecs[5] = mk(0,   3,  0, 15,  2, -1, 0, 0,  2,  0, 15);
    vecs[6] = mk(1,   0,  0,  0,  0, -1, 0, 1,  0,  0,  0);
    vecs[7] = mk(2,   0,  0,  0,  0, -1, 0, 1,  0,  0,  0);

    rst = 1'b0; start = 1'b0; sad_in = '0;
    for (int i = 0; i < LAT; i++) issue_q.push_back(-1);
    for (int x = 0; x < NCAND; x++)
      for (int k = 0; k < LANES; k++) cand[x][k] = '0;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      run_vector(mk((i % 2) + 1, 0, 0, 0, 0, -1, 0, 1, 0, 0, 0), $sformatf("rand%0d", i));
      tick();
    end

    // Reset during DRAIN abandons the search without a done pulse.
    fill(mk(0, 100, 3, 3, 1, -1, 0, 0, 1, 3, 3));
    done_cnt = 0;
    s = cyc;
    start = 1'b1;
    while (cyc < s + 40) begin
      tick();
      start = 1'b0;
      if (done) done_cnt++;
    end
    check("drain_state_busy", busy, 1);
    rst = 1'b0;
    tick();
    check_reset_values("midreset");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("midreset no_done", done_cnt, 0);
    run_vector(mk(0, 200, 18, 6, 9, -1, 0, 0, 9, 18, 6), "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/me_search_ctrl.md
ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

Interface
REQ-001 Parameter EDGE_LEN, default 8: block edge length in pixels.
REQ-002 Parameter LOG_EDGE_LEN, default 3: log2(EDGE_LEN).
REQ-003 Parameter BIT_DEPTH, default 8: bits per pixel.
REQ-004 Parameter PIXELS_IN_BATCH, default 16: vertical candidates (lanes) evaluated per column.
REQ-005 Parameter SEARCH_COLS, default 32: reference columns per search; LOG_SEARCH_COLS default 5.
REQ-006 Parameter ARRAY_LATENCY, default 2*EDGE_LEN: cycles from a column issued on ref_col_en until its contribution appears on sad_in.
REQ-007 clk  input  1  single clock; all logic rising-edge.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 start  input  1  one-cycle search request; ignored unless IDLE.
REQ-010 busy  output  1  high from start acceptance until done pulse inclusive.
REQ-011 cur_load  output  1  one-cycle pulse latching current block into array input register.
REQ-012 ref_col_en  output  1  reference column issued to array this cycle.
REQ-013 ref_col_addr  output  LOG_SEARCH_COLS  column index 0..SEARCH_COLS-1 of issued column.
REQ-014 sad_in  input  PIXELS_IN_BATCH*(2*LOG_EDGE_LEN+BIT_DEPTH)  array SAD bus, lane k in bits [(k+1)*W-1 : k*W], W=2*LOG_EDGE_LEN+BIT_DEPTH.
REQ-015 done  output  1  one-cycle pulse; best_* valid from this cycle until next start.
REQ-016 best_sad  output  W  minimum SAD of completed search.
REQ-017 best_x  output  LOG_SEARCH_COLS  candidate column index of minimum.
REQ-018 best_y  output  log2(PIXELS_IN_BATCH)  lane index of minimum.

Function
REQ-019 States IDLE, LOAD, FEED, DRAIN, DONE; IDLE->LOAD on start, LOAD->FEED after 1 cycle, FEED->DRAIN after SEARCH_COLS cycles, DRAIN->DONE when last candidate sampled, DONE->IDLE after 1 cycle.
REQ-020 cur_load asserted exactly in LOAD.
REQ-021 In FEED, ref_col_en=1 every cycle, ref_col_addr counts 0..SEARCH_COLS-1 without gaps or stalls.
REQ-022 Issued column c>=EDGE_LEN-1 yields candidate x=c-(EDGE_LEN-1); its sad_in is sampled exactly ARRAY_LATENCY cycles after issue.
REQ-023 Number of candidates NCAND=SEARCH_COLS-EDGE_LEN+1 (default 25); last sample at FEED-start + SEARCH_COLS-1 + ARRAY_LATENCY.
REQ-024 Sampling driven by a delay-line/counter of issue events, not by sad_in content.
REQ-025 Per sample, min of PIXELS_IN_BATCH lanes is found combinationally; ties resolve to lowest lane.
REQ-026 Running minimum updates only on strictly smaller value; ties keep earliest x.
REQ-027 Running minimum initialised to all-ones at LOAD; comparisons unsigned, width W, no saturation.
REQ-028 best_sad/best_x/best_y registered, updated in DONE, held otherwise; done=1 only in DONE.
REQ-029 start while busy ignored with no effect on state or outputs; start in DONE cycle ignored.
REQ-030 ref_col_en=0 and cur_load=0 outside FEED/LOAD.

Reset
REQ-031 rst=0 at any clock edge forces IDLE, busy=0, done=0, cur_load=0, ref_col_en=0, ref_col_addr=0, best_sad=0, best_x=0, best_y=0, running min all-ones, delay line cleared.
REQ-032 Reset mid-search abandons it; no done pulse; first start after release starts a fresh search.

Structure
REQ-033 Shared package holds state encoding, W, NCAND and counter widths derived from parameters.
REQ-034 One sub-module sad_min_tree: combinational PIXELS_IN_BATCH-lane minimum with index, lowest-index tie-break.

Verification
REQ-035 Reset then start; all lanes sad_in=100 except candidate x=7 lane 3 =5 -> done at cycle 1+1+32+15+ARRAY_LATENCY-... per REQ-023, best_sad=5, best_x=7, best_y=3.
REQ-036 All samples equal 42 -> best_sad=42, best_x=0, best_y=0 (tie rule).
REQ-037 Candidate x=24 lane 15 =0, others 1 -> best_x=24, best_y=15 (last-candidate boundary).
REQ-038 start re-pulsed at FEED cycle 10 -> ref_col_addr sequence 0..31 unbroken, single done.
REQ-039 rst=0 during DRAIN, released, start again -> no done from first search; second completes with correct result.
REQ-040 Cycle check: ref_col_en high exactly 32 consecutive cycles, cur_load exactly 1 cycle before first.
